// File: rtl/pwm_regbank_shadow_if.sv
// rtl/pwm_regbank_shadow_if.sv - register bus interface for the PWM shadow register bank
// Word-addressed single-beat bus: one write or read strobe per cycle, reads return one cycle later.
interface pwm_regbank_shadow_if #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 8
);
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] addr;
   logic [WIDTH-1:0]  wr_data;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;

   modport master (output wr_en, rd_en, addr, wr_data, input rd_data, rd_valid);
   modport slave  (input wr_en, rd_en, addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/pwm_regbank_shadow.sv
// rtl/pwm_regbank_shadow.sv - multi-channel PWM register bank with shadow/active pairs
// Software writes land in the shadow set; the PWM cores only ever see the active set.
module pwm_regbank_shadow #(
   parameter int WIDTH  = 16,
   parameter int N_CH   = 4,
   parameter int ADDR_W = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   pwm_regbank_shadow_if.slave     bus,
   input  logic [N_CH-1:0]         upd_evt_i,
   output logic                    g_en_o,
   output logic [N_CH-1:0]         ch_en_o,
   output logic [N_CH-1:0]         ch_mode_o,
   output logic [N_CH-1:0]         ch_dt_en_o,
   output logic [N_CH*WIDTH-1:0]   ch_period_o,
   output logic [N_CH*WIDTH-1:0]   ch_duty1_o,
   output logic [N_CH*WIDTH-1:0]   ch_duty2_o,
   output logic [N_CH*WIDTH-1:0]   ch_deadtime_o,
   output logic [N_CH*WIDTH-1:0]   ch_prescaler_o,
   output logic [N_CH*WIDTH-1:0]   ch_delay1_o,
   output logic [N_CH*WIDTH-1:0]   ch_delay2_o,
   output logic [N_CH-1:0]         upd_pending_o
);
   localparam int NVAL = 7;

   logic             g_en_q, g_en_d;
   logic             lock_q, lock_d;
   logic             err_q, err_d;
   logic [N_CH-1:0]  pend_q, pend_d;
   logic [3:0]       sh_ctrl_q [N_CH];
   logic [3:0]       sh_ctrl_d [N_CH];
   logic [3:0]       act_ctrl_q [N_CH];
   logic [3:0]       act_ctrl_d [N_CH];
   logic [WIDTH-1:0] sh_val_q [N_CH][NVAL];
   logic [WIDTH-1:0] sh_val_d [N_CH][NVAL];
   logic [WIDTH-1:0] act_val_q [N_CH][NVAL];
   logic [WIDTH-1:0] act_val_d [N_CH][NVAL];
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;

   logic [ADDR_W-1:0] ch_rel;
   logic [ADDR_W-4:0] ch_idx;
   logic [2:0]        ch_off;
   logic              is_ch_space;
   logic [N_CH-1:0]   ch_wr;
   logic              force_upd;

   always_comb begin
      ch_rel      = bus.addr - ADDR_W'(16);
      ch_idx      = ch_rel[ADDR_W-1:3];
      ch_off      = ch_rel[2:0];
      is_ch_space = (bus.addr >= ADDR_W'(16)) && (ch_idx < (ADDR_W-3)'(N_CH));
   end

   always_comb begin
      g_en_d     = g_en_q;
      lock_d     = lock_q;
      err_d      = err_q;
      pend_d     = pend_q;
      sh_ctrl_d  = sh_ctrl_q;
      act_ctrl_d = act_ctrl_q;
      sh_val_d   = sh_val_q;
      act_val_d  = act_val_q;
      force_upd  = 1'b0;
      ch_wr      = '0;

      if (bus.wr_en) begin
         // STATUS is the only register still writable once locked
         if (bus.addr == ADDR_W'(1)) begin
            if (bus.wr_data[WIDTH-1:1] != '0) begin
               err_d = 1'b1;
            end else if (bus.wr_data[0]) begin
               err_d = 1'b0;
            end
         end else if (lock_q) begin
            err_d = 1'b1;
         end else if (bus.addr == '0) begin
            g_en_d    = bus.wr_data[0];
            lock_d    = bus.wr_data[1];
            force_upd = bus.wr_data[2];
         end else if (is_ch_space) begin
            for (int c = 0; c < N_CH; c++) begin
               ch_wr[c] = (ch_idx == (ADDR_W-3)'(c));
            end
         end else begin
            err_d = 1'b1;
         end
      end

      for (int c = 0; c < N_CH; c++) begin
         // Transfer first from the pre-write shadow, so a colliding write stays pending
         if (pend_q[c] && (upd_evt_i[c] || force_upd)) begin
            act_ctrl_d[c] = sh_ctrl_q[c];
            for (int r = 0; r < NVAL; r++) begin
               act_val_d[c][r] = sh_val_q[c][r];
            end
            pend_d[c] = 1'b0;
         end
         if (ch_wr[c]) begin
            if (ch_off == 3'd0) begin
               sh_ctrl_d[c] = bus.wr_data[3:0];
               if (!sh_ctrl_q[c][2]) begin
                  act_ctrl_d[c] = bus.wr_data[3:0];
               end else begin
                  act_ctrl_d[c][2] = bus.wr_data[2];
               end
            end else begin
               sh_val_d[c][ch_off - 3'd1] = bus.wr_data;
               if (!sh_ctrl_q[c][2]) begin
                  act_val_d[c][ch_off - 3'd1] = bus.wr_data;
               end
            end
            if (sh_ctrl_q[c][2]) begin
               pend_d[c] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      rd_valid_d = bus.rd_en;
      rd_data_d  = rd_data_q;
      if (bus.rd_en) begin
         rd_data_d = '0;
         if (bus.addr == '0) begin
            rd_data_d[1:0] = {lock_q, g_en_q};
         end else if (bus.addr == ADDR_W'(1)) begin
            rd_data_d[0] = err_q;
            for (int c = 0; c < N_CH; c++) begin
               if (c + 1 < WIDTH) begin
                  rd_data_d[c+1] = pend_q[c];
               end
            end
         end else if (is_ch_space) begin
            for (int c = 0; c < N_CH; c++) begin
               if (ch_idx == (ADDR_W-3)'(c)) begin
                  if (ch_off == 3'd0) begin
                     rd_data_d[3:0] = sh_ctrl_q[c];
                  end else begin
                     rd_data_d = sh_val_q[c][ch_off - 3'd1];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         g_en_q     <= 1'b0;
         lock_q     <= 1'b0;
         err_q      <= 1'b0;
         pend_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         for (int c = 0; c < N_CH; c++) begin
            sh_ctrl_q[c]  <= '0;
            act_ctrl_q[c] <= '0;
            for (int r = 0; r < NVAL; r++) begin
               sh_val_q[c][r]  <= '0;
               act_val_q[c][r] <= '0;
            end
         end
      end else begin
         g_en_q     <= g_en_d;
         lock_q     <= lock_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         sh_ctrl_q  <= sh_ctrl_d;
         act_ctrl_q <= act_ctrl_d;
         sh_val_q   <= sh_val_d;
         act_val_q  <= act_val_d;
      end
   end

   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign g_en_o        = g_en_q;
   assign upd_pending_o = pend_q;

   for (genvar c = 0; c < N_CH; c++) begin : g_out
      assign ch_en_o[c]                         = act_ctrl_q[c][0];
      assign ch_mode_o[c]                       = act_ctrl_q[c][1];
      assign ch_dt_en_o[c]                      = act_ctrl_q[c][3];
      assign ch_period_o[c*WIDTH +: WIDTH]      = act_val_q[c][0];
      assign ch_duty1_o[c*WIDTH +: WIDTH]       = act_val_q[c][1];
      assign ch_duty2_o[c*WIDTH +: WIDTH]       = act_val_q[c][2];
      assign ch_deadtime_o[c*WIDTH +: WIDTH]    = act_val_q[c][3];
      assign ch_prescaler_o[c*WIDTH +: WIDTH]   = act_val_q[c][4];
      assign ch_delay1_o[c*WIDTH +: WIDTH]      = act_val_q[c][5];
      assign ch_delay2_o[c*WIDTH +: WIDTH]      = act_val_q[c][6];
   end
endmodule

// File: tb/tb_pwm_regbank_shadow.sv
// tb/tb_pwm_regbank_shadow.sv - self-checking bench for pwm_regbank_shadow
// Directed plan steps plus random traffic, checked against an array-based register model.
module tb_pwm_regbank_shadow;
   localparam int WIDTH  = 16;
   localparam int N_CH   = 4;
   localparam int ADDR_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pwm_regbank_shadow_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus_if ();

   logic [N_CH-1:0]       upd_evt;
   logic                  g_en;
   logic [N_CH-1:0]       ch_en, ch_mode, ch_dt_en, upd_pending;
   logic [N_CH*WIDTH-1:0] ch_period, ch_duty1, ch_duty2, ch_deadtime;
   logic [N_CH*WIDTH-1:0] ch_prescaler, ch_delay1, ch_delay2;

   pwm_regbank_shadow #(.WIDTH(WIDTH), .N_CH(N_CH), .ADDR_W(ADDR_W)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .bus            (bus_if.slave),
      .upd_evt_i      (upd_evt),
      .g_en_o         (g_en),
      .ch_en_o        (ch_en),
      .ch_mode_o      (ch_mode),
      .ch_dt_en_o     (ch_dt_en),
      .ch_period_o    (ch_period),
      .ch_duty1_o     (ch_duty1),
      .ch_duty2_o     (ch_duty2),
      .ch_deadtime_o  (ch_deadtime),
      .ch_prescaler_o (ch_prescaler),
      .ch_delay1_o    (ch_delay1),
      .ch_delay2_o    (ch_delay2),
      .upd_pending_o  (upd_pending)
   );

   int total = 0;
   int bad   = 0;

   // Model: index 0 is CTRL, 1..7 are PERIOD..DELAY2
   int            m_sh  [N_CH][8];
   int            m_act [N_CH][8];
   bit [N_CH-1:0] m_pend;
   bit            m_err, m_lock, m_gen;
   int            m_rd_last;

   task automatic chk(string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_read(int a);
      int r = 0;
      if (a == 0) r = int'(m_gen) | (int'(m_lock) << 1);
      else if (a == 1) r = int'(m_err) | (int'(m_pend) << 1);
      else if (a >= 16 && (a - 16) / 8 < N_CH) r = m_sh[(a - 16) / 8][(a - 16) % 8];
      return r;
   endfunction

   task automatic model_clear();
      for (int c = 0; c < N_CH; c++)
         for (int r = 0; r < 8; r++) begin
            m_sh[c][r]  = 0;
            m_act[c][r] = 0;
         end
      m_pend = '0; m_err = 0; m_lock = 0; m_gen = 0; m_rd_last = 0;
   endtask

   task automatic check_outs();
      logic [N_CH*WIDTH-1:0] ev [7];
      logic [N_CH-1:0]       een, emode, edt;
      for (int c = 0; c < N_CH; c++) begin
         een[c]   = m_act[c][0][0];
         emode[c] = m_act[c][0][1];
         edt[c]   = m_act[c][0][3];
         for (int r = 1; r < 8; r++) ev[r-1][c*WIDTH +: WIDTH] = m_act[c][r][WIDTH-1:0];
      end
      chk("g_en", g_en, m_gen);
      chk("ch_en", ch_en, een);
      chk("ch_mode", ch_mode, emode);
      chk("ch_dt_en", ch_dt_en, edt);
      chk("upd_pending", upd_pending, m_pend);
      chk("ch_period", ch_period, ev[0]);
      chk("ch_duty1", ch_duty1, ev[1]);
      chk("ch_duty2", ch_duty2, ev[2]);
      chk("ch_deadtime", ch_deadtime, ev[3]);
      chk("ch_prescaler", ch_prescaler, ev[4]);
      chk("ch_delay1", ch_delay1, ev[5]);
      chk("ch_delay2", ch_delay2, ev[6]);
   endtask

   task automatic step(bit wr, bit rd, int a, int din, bit [N_CH-1:0] evt);
      int d, exp_rd, wc, wo;
      int old_sh [N_CH][8];
      bit frc;
      d      = din & 'hFFFF;
      exp_rd = model_read(a);
      bus_if.wr_en   = wr;
      bus_if.rd_en   = rd;
      bus_if.addr    = a[ADDR_W-1:0];
      bus_if.wr_data = d[WIDTH-1:0];
      upd_evt        = evt;

      frc = 0; wc = -1; wo = 0;
      if (wr) begin
         if (a == 1) begin
            if (d > 1) m_err = 1;
            else if (d == 1) m_err = 0;
         end else if (m_lock) m_err = 1;
         else if (a == 0) begin
            m_gen = d[0]; m_lock = d[1]; frc = d[2];
         end else if (a >= 16 && (a - 16) / 8 < N_CH) begin
            wc = (a - 16) / 8; wo = (a - 16) % 8;
         end else m_err = 1;
      end
      old_sh = m_sh;
      for (int c = 0; c < N_CH; c++)
         if (m_pend[c] && (evt[c] || frc)) begin
            for (int r = 0; r < 8; r++) m_act[c][r] = old_sh[c][r];
            m_pend[c] = 0;
         end
      if (wc >= 0) begin
         m_sh[wc][wo] = (wo == 0) ? (d & 'hF) : d;
         if (old_sh[wc][0][2] == 1'b0) m_act[wc][wo] = m_sh[wc][wo];
         else begin
            m_pend[wc] = 1;
            if (wo == 0) m_act[wc][0][2] = d[2];
         end
      end

      @(posedge clk);
      #1;
      bus_if.wr_en = 1'b0;
      bus_if.rd_en = 1'b0;
      upd_evt      = '0;
      if (rd) m_rd_last = exp_rd;
      chk("rd_valid", bus_if.rd_valid, rd);
      chk("rd_data", bus_if.rd_data, m_rd_last[WIDTH-1:0]);
      check_outs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      chk("rst_rd_valid", bus_if.rd_valid, 1'b0);
      chk("rst_rd_data", bus_if.rd_data, 16'h0);
      check_outs();
   endtask

   task automatic rand_traffic(int n);
      int kind, a, d;
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(0, 9);
         d    = $urandom & 'hFFFF;
         if (kind == 0) begin a = 0; d = d & 'hFFFD; end
         else if (kind == 1) begin a = 1; d = $urandom_range(0, 3); end
         else if (kind == 2) a = $urandom_range(2, 15);
         else a = 16 + $urandom_range(0, 8 * N_CH + 7);
         step($urandom_range(0, 1), $urandom_range(0, 1), a, d, N_CH'($urandom & $urandom));
      end
   endtask

   initial begin
      int saved;
      rst = 1'b1;
      bus_if.wr_en = 1'b0; bus_if.rd_en = 1'b0; bus_if.addr = '0; bus_if.wr_data = '0;
      upd_evt = '0;
      model_clear();
      do_reset();

      // Plan 1: every mapped address reads zero
      step(0, 1, 0, 0, '0);
      step(0, 1, 1, 0, '0);
      for (int a = 16; a < 16 + 8 * N_CH; a++) step(0, 1, a, 0, '0);

      // Plan 2: immediate load without preload
      step(1, 0, 16 + 8 + 1, 'h0100, '0);
      chk("t2_period", ch_period[31:16], 16'h0100);
      chk("t2_pend", upd_pending[1], 1'b0);

      // Plan 3: preload holds until the period event
      step(1, 0, 16, 4, '0);
      step(1, 0, 16 + 2, 'h40, '0);
      chk("t3_hold", ch_duty1[15:0], 16'h0);
      chk("t3_pend", upd_pending[0], 1'b1);
      step(0, 0, 0, 0, 4'b0001);
      chk("t3_xfer", ch_duty1[15:0], 16'h0040);
      chk("t3_pend_clr", upd_pending[0], 1'b0);

      // Plan 4: write colliding with an event, then force
      step(1, 0, 32, 4, '0);
      step(1, 0, 32 + 3, 'h10, '0);
      step(0, 0, 0, 0, 4'b0100);
      step(1, 0, 32 + 3, 'h20, 4'b0100);
      chk("t4_collide", ch_duty2[47:32], 16'h0010);
      chk("t4_pend", upd_pending[2], 1'b1);
      step(1, 0, 0, 4, '0);
      chk("t4_force", ch_duty2[47:32], 16'h0020);
      chk("t4_pend_clr", upd_pending[2], 1'b0);

      rand_traffic(400);

      // Plan 6: write beyond last channel
      step(1, 0, 1, 1, '0);
      step(1, 0, 16 + 8 * N_CH, 'h1234, '0);
      step(0, 1, 1, 0, '0);
      chk("t6_err", bus_if.rd_data[0], 1'b1);
      step(0, 1, 16 + 8 * N_CH, 0, '0);
      chk("t6_rd", bus_if.rd_data, 16'h0);
      chk("t6_rd_valid", bus_if.rd_valid, 1'b1);
      step(1, 0, 1, 1, '0);

      // Plan 5: lock
      step(1, 0, 0, 2, '0);
      saved = m_sh[0][1];
      step(1, 0, 17, 'h55, '0);
      step(0, 1, 17, 0, '0);
      chk("t5_shadow", bus_if.rd_data, saved[WIDTH-1:0]);
      step(0, 1, 1, 0, '0);
      chk("t5_err", bus_if.rd_data[0], 1'b1);
      step(1, 0, 1, 1, '0);
      step(0, 1, 1, 0, '0);
      chk("t5_err_clr", bus_if.rd_data[0], 1'b0);
      step(0, 1, 0, 0, '0);
      chk("t5_lock", bus_if.rd_data[1], 1'b1);
      rand_traffic(60);

      do_reset();
      step(0, 1, 0, 0, '0);
      chk("final_gctrl", bus_if.rd_data, 16'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pwm_regbank_shadow.md
Name: pwm_regbank_shadow

Overview:
Multi-channel successor to the single-channel PWM register file. It provides N_CH independent PWM channel configurations, each with shadow (software-visible) and active (core-visible) register pairs. Shadow-to-active transfer happens on a per-channel period-boundary event, by software force, or immediately when preload is off. It adds registered reads, a configuration lock and a sticky error flag, and sits between the bus slave and the PWM cores.

Parameters:
WIDTH, 16, data/register width (min 4)
N_CH, 4, number of PWM channels (1..16)
ADDR_W, 8, byte-free word address width; must cover 0x10 + 8*N_CH - 1

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write strobe, one word per cycle
rd_en  in  1  read strobe
addr  in  ADDR_W  word address
wr_data  in  WIDTH  write data
rd_data  out  WIDTH  read data, registered
rd_valid  out  1  high one cycle after an accepted rd_en
upd_evt  in  N_CH  per-channel period-end pulse from the PWM cores
g_en  out  1  global enable
ch_en, ch_mode, ch_dt_en  out  N_CH each  active per-channel control bits
ch_period, ch_duty1, ch_duty2, ch_deadtime, ch_prescaler, ch_delay1, ch_delay2  out  N_CH*WIDTH each  active values, channel c at bits [c*WIDTH +: WIDTH]
upd_pending  out  N_CH  shadow differs from active, transfer outstanding

Behaviour:
- Address map:
  - 0x00 GCTRL: bit0 g_en, bit1 lock (set-only), bit2 force_upd (write-1 pulse, reads 0).
  - 0x01 STATUS: bit0 err (sticky, W1C), bits[N_CH+0:1] upd_pending (RO).
  - Channel c base = 0x10 + 8*c, with offsets: +0 CTRL (bit0 en, bit1 mode, bit2 preload_en, bit3 dt_en), +1 PERIOD, +2 DUTY1, +3 DUTY2, +4 DEADTIME, +5 PRESCALER, +6 DELAY1, +7 DELAY2.
- Reset (rst=1 at a clk edge):
  - All shadow, active, GCTRL, err, pending, rd_data and rd_valid go to 0.
  - All outputs read 0 the cycle after.
- Writes:
  - A channel write updates the shadow on the next edge.
  - If that channel's preload_en (shadow CTRL bit2, value before this write) is 0, the active register loads the same data on the same edge.
  - Otherwise pending[c] is set.
  - CTRL preload_en itself always takes effect immediately in both shadow and active.
- Transfer:
  - When upd_evt[c]=1 and pending[c]=1, all active registers of channel c load the shadow values and pending[c] clears on that edge.
  - force_upd=1 transfers all channels with pending set, on the same edge as the GCTRL write.
- Simultaneous write to channel c and upd_evt[c]: the active registers take the shadow values from before the write. pending[c] stays 1 so the new value transfers at the next event.
- upd_evt[c] with pending[c]=0: no effect.
- Lock:
  - Once lock=1, all writes except STATUS W1C are ignored and set err. Cleared only by rst.
  - Transfers of already-pending values still occur while locked.
- Error: writes to unmapped addresses, to STATUS bits other than bit0, or to channel indices >= N_CH are ignored and set err=1.
- Reads:
  - 1-cycle latency. rd_data and rd_valid are registered on the edge after rd_en.
  - Channel reads return shadow values. Reserved bits read 0. Unmapped addresses return 0 and do not set err.
- rd_en and wr_en to the same address in the same cycle: the read returns the pre-write value.
- rd_data holds its last value when rd_valid=0.

Test Plan:
1. Reset, then read every mapped address -> all 0, rd_valid one cycle after each rd_en, err=0.
2. Ch1 preload_en=0, write PERIOD=0x0100 -> ch_period[31:16]=0x0100 one cycle after wr_en, upd_pending[1]=0.
3. Ch0 preload_en=1, write DUTY1=0x0040 -> active stays 0 and pending[0]=1. Pulse upd_evt[0] -> active=0x0040, pending[0]=0.
4. Ch2 preload on: write DUTY2=0x10, pulse upd_evt[2], then write DUTY2=0x20 in the same cycle as a second upd_evt[2] -> active=0x10 and pending[2]=1. Write GCTRL force_upd -> active=0x20.
5. Set lock, then write ch0 PERIOD=0x55 -> shadow unchanged and STATUS.err=1. Write STATUS=0x1 -> err=0. Lock remains 1.
6. Write to address 0x10+8*N_CH -> err=1, no register changes. Read of the same address returns 0 with rd_valid=1.
